// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the 6502 ALU sequencer.
// Decimal-mode support is built only when ALU_SEQ_DECIMAL_EN is defined.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OpAdc = 4'd0,
    OpSbc = 4'd1,
    OpAnd = 4'd2,
    OpOra = 4'd3,
    OpEor = 4'd4,
    OpLsr = 4'd5,
    OpInc = 4'd6,
    OpDec = 4'd7,
    OpCmp = 4'd8
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StAdj  = 2'd2,
    StDone = 2'd3
  } seq_state_e;

  localparam logic [7:0] BcdLoAdj = 8'h06;
  localparam logic [7:0] BcdHiAdj = 8'h60;

  // Every line driven towards the ALU; registered as one word.
  typedef struct packed {
    logic [7:0] sb;
    logic [7:0] db;
    logic [7:0] adl;
    logic       sb_add;
    logic       db_add;
    logic       db_n_add;
    logic       adl_add;
    logic       zero_add;
    logic       one_addc;
    logic       sums;
    logic       ands;
    logic       eors;
    logic       ors;
    logic       srs;
  } alu_drive_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response and ALU-drive bundle for alu_sequencer.
// slave is the sequencer; master is the control logic plus ALU side.
interface alu_sequencer_if;
  logic       i_req;
  logic [3:0] i_op;
  logic [7:0] i_a;
  logic [7:0] i_m;
  logic       i_c;
  logic       i_v;
  logic       i_d;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_result;
  logic       o_n;
  logic       o_z;
  logic       o_c;
  logic       o_v;
  logic [7:0] o_sb;
  logic [7:0] o_db;
  logic [7:0] o_adl;
  logic       o_sb_add;
  logic       o_db_add;
  logic       o_db_n_add;
  logic       o_adl_add;
  logic       o_0_add;
  logic       o_1_addc;
  logic       o_sums;
  logic       o_ands;
  logic       o_eors;
  logic       o_ors;
  logic       o_srs;
  logic [7:0] i_add;

  modport slave (
    input  i_req, i_op, i_a, i_m, i_c, i_v, i_d, i_add,
    output o_busy, o_done, o_result, o_n, o_z, o_c, o_v,
    output o_sb, o_db, o_adl, o_sb_add, o_db_add, o_db_n_add, o_adl_add, o_0_add, o_1_addc,
    output o_sums, o_ands, o_eors, o_ors, o_srs
  );

  modport master (
    output i_req, i_op, i_a, i_m, i_c, i_v, i_d, i_add,
    input  o_busy, o_done, o_result, o_n, o_z, o_c, o_v,
    input  o_sb, o_db, o_adl, o_sb_add, o_db_add, o_db_n_add, o_adl_add, o_0_add, o_1_addc,
    input  o_sums, o_ands, o_eors, o_ors, o_srs
  );
endinterface

// File: rtl/alu_seq_bcd_adjust.sv
// Decimal adjust constant and decimal carry for ADC/SBC (used under ALU_SEQ_DECIMAL_EN).
// i_b is the effective B operand (m for add, ~m for subtract).
module alu_seq_bcd_adjust
  import alu_seq_pkg::*;
(
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_c,
  input  logic       i_sub,
  output logic [7:0] o_adj,
  output logic       o_carry
);

  logic [4:0] w_lo;
  logic [8:0] w_sum;
  logic       w_lo_adj;
  logic       w_hi_adj;

  always_comb begin
    w_lo  = {1'b0, i_a[3:0]} + {1'b0, i_b[3:0]} + {4'b0000, i_c};
    w_sum = {1'b0, i_a} + {1'b0, i_b} + {8'h00, i_c};
    if (i_sub) begin
      // A missing nibble carry means that nibble borrowed.
      w_lo_adj = ~w_lo[4];
      w_hi_adj = ~w_sum[8];
      o_carry  = w_sum[8];
    end else begin
      w_lo_adj = (w_lo > 5'd9);
      w_hi_adj = (w_sum > 9'h099);
      o_carry  = w_hi_adj;
    end
    o_adj = (w_lo_adj ? BcdLoAdj : 8'h00) | (w_hi_adj ? BcdHiAdj : 8'h00);
  end

endmodule

// File: rtl/alu_sequencer.sv
// Drives the 6502 ALU for one request and returns a registered result with N/Z/C/V.
// Define ALU_SEQ_DECIMAL_EN to add the decimal adjust pass for ADC/SBC.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input logic            i_clk,
  input logic            i_reset_n,
  alu_sequencer_if.slave bus
);

  seq_state_e r_state, w_state_nxt;
  logic [7:0] r_a, w_a_nxt, r_m, w_m_nxt;
  logic [3:0] r_op, w_op_nxt;
  logic       r_c, w_c_nxt, r_v, w_v_nxt;
  alu_drive_t r_drv, w_drv_nxt;
  logic [7:0] r_result, w_result_nxt;
  logic       r_flag_n, w_flag_n_nxt, r_flag_z, w_flag_z_nxt;
  logic       r_flag_c, w_flag_c_nxt, r_flag_v, w_flag_v_nxt;

  logic [7:0] w_a_eff, w_b_eff;
  logic       w_cin_eff;
  logic [8:0] w_sum;
  logic       w_v_bin, w_c_sel, w_v_sel;

`ifdef ALU_SEQ_DECIMAL_EN
  logic       r_d, w_d_nxt;
  logic [7:0] w_adj;
  logic       w_dec_carry;
  logic       w_dec_mode;

  alu_seq_bcd_adjust u_bcd_adjust (
    .i_a     (r_a),
    .i_b     (w_b_eff),
    .i_c     (r_c),
    .i_sub   (r_op == OpSbc),
    .o_adj   (w_adj),
    .o_carry (w_dec_carry)
  );

  assign w_dec_mode = r_d && ((r_op == OpAdc) || (r_op == OpSbc));
`else
  logic w_unused_d;
  assign w_unused_d = bus.i_d;
`endif

  function automatic alu_drive_t exec_drive(input logic [3:0] op, input logic [7:0] a,
                                            input logic [7:0] m, input logic c);
    alu_drive_t d = '0;
    case (alu_op_e'(op))
      OpAdc: begin d.sb = a; d.db = m; d.sb_add = 1'b1; d.db_add = 1'b1;
                   d.one_addc = c; d.sums = 1'b1; end
      OpSbc: begin d.sb = a; d.db = m; d.sb_add = 1'b1; d.db_n_add = 1'b1;
                   d.one_addc = c; d.sums = 1'b1; end
      OpAnd: begin d.sb = a; d.db = m; d.sb_add = 1'b1; d.db_add = 1'b1; d.ands = 1'b1; end
      OpOra: begin d.sb = a; d.db = m; d.sb_add = 1'b1; d.db_add = 1'b1; d.ors = 1'b1; end
      OpEor: begin d.sb = a; d.db = m; d.sb_add = 1'b1; d.db_add = 1'b1; d.eors = 1'b1; end
      OpLsr: begin d.sb = a; d.sb_add = 1'b1; d.srs = 1'b1; end
      OpInc: begin d.sb = m; d.sb_add = 1'b1; d.db = 8'h00; d.db_add = 1'b1;
                   d.one_addc = 1'b1; d.sums = 1'b1; end
      // No B select: the ALU supplies 0xFF, so m + 0xFF + 0 = m - 1.
      OpDec: begin d.sb = m; d.sb_add = 1'b1; d.sums = 1'b1; end
      OpCmp: begin d.sb = a; d.db = m; d.sb_add = 1'b1; d.db_n_add = 1'b1;
                   d.one_addc = 1'b1; d.sums = 1'b1; end
      default: ;
    endcase
    return d;
  endfunction

  // Reference sum for carry/overflow, independent of the ALU read-back.
  always_comb begin
    w_a_eff   = r_a;
    w_b_eff   = 8'h00;
    w_cin_eff = r_c;
    case (alu_op_e'(r_op))
      OpAdc:   w_b_eff = r_m;
      OpSbc:   w_b_eff = ~r_m;
      OpCmp:   begin w_b_eff = ~r_m; w_cin_eff = 1'b1; end
      OpInc:   begin w_a_eff = r_m; w_cin_eff = 1'b1; end
      OpDec:   begin w_a_eff = r_m; w_b_eff = 8'hFF; w_cin_eff = 1'b0; end
      default: ;
    endcase
    w_sum   = {1'b0, w_a_eff} + {1'b0, w_b_eff} + {8'h00, w_cin_eff};
    w_v_bin = (r_a[7] ^ w_sum[7]) & (w_b_eff[7] ^ w_sum[7]);
    w_c_sel = r_c;
    w_v_sel = r_v;
    case (alu_op_e'(r_op))
      OpAdc, OpSbc: begin w_c_sel = w_sum[8]; w_v_sel = w_v_bin; end
      OpCmp:        w_c_sel = w_sum[8];
      OpLsr:        w_c_sel = r_a[0];
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_m_nxt      = r_m;
    w_op_nxt     = r_op;
    w_c_nxt      = r_c;
    w_v_nxt      = r_v;
    w_drv_nxt    = '0;
    w_result_nxt = r_result;
    w_flag_n_nxt = r_flag_n;
    w_flag_z_nxt = r_flag_z;
    w_flag_c_nxt = r_flag_c;
    w_flag_v_nxt = r_flag_v;
`ifdef ALU_SEQ_DECIMAL_EN
    w_d_nxt      = r_d;
`endif
    case (r_state)
      StIdle: begin
        if (bus.i_req) begin
          w_a_nxt     = bus.i_a;
          w_m_nxt     = bus.i_m;
          w_op_nxt    = bus.i_op;
          w_c_nxt     = bus.i_c;
          w_v_nxt     = bus.i_v;
`ifdef ALU_SEQ_DECIMAL_EN
          w_d_nxt     = bus.i_d;
`endif
          w_drv_nxt   = exec_drive(bus.i_op, bus.i_a, bus.i_m, bus.i_c);
          w_state_nxt = StExec;
        end
      end
      StExec: begin
`ifdef ALU_SEQ_DECIMAL_EN
        if (w_dec_mode) begin
          // Second pass adds (ADC) or subtracts (SBC) the adjust from the binary result.
          w_drv_nxt.sb     = bus.i_add;
          w_drv_nxt.sb_add = 1'b1;
          w_drv_nxt.sums   = 1'b1;
          if (r_op == OpSbc) begin
            w_drv_nxt.db       = w_adj;
            w_drv_nxt.db_n_add = 1'b1;
            w_drv_nxt.one_addc = 1'b1;
          end else begin
            w_drv_nxt.adl     = w_adj;
            w_drv_nxt.adl_add = 1'b1;
          end
          w_state_nxt = StAdj;
        end else
`endif
        begin
          w_result_nxt = bus.i_add;
          w_flag_n_nxt = bus.i_add[7];
          w_flag_z_nxt = (bus.i_add == 8'h00);
          w_flag_c_nxt = w_c_sel;
          w_flag_v_nxt = w_v_sel;
          w_state_nxt  = StDone;
        end
      end
`ifdef ALU_SEQ_DECIMAL_EN
      StAdj: begin
        w_result_nxt = bus.i_add;
        w_flag_n_nxt = bus.i_add[7];
        w_flag_z_nxt = (bus.i_add == 8'h00);
        w_flag_c_nxt = w_dec_carry;
        w_flag_v_nxt = w_v_bin;
        w_state_nxt  = StDone;
      end
`endif
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= StIdle;
      r_a      <= '0;
      r_m      <= '0;
      r_op     <= '0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
      r_drv    <= '0;
      r_result <= '0;
      r_flag_n <= 1'b0;
      r_flag_z <= 1'b0;
      r_flag_c <= 1'b0;
      r_flag_v <= 1'b0;
`ifdef ALU_SEQ_DECIMAL_EN
      r_d      <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_a      <= w_a_nxt;
      r_m      <= w_m_nxt;
      r_op     <= w_op_nxt;
      r_c      <= w_c_nxt;
      r_v      <= w_v_nxt;
      r_drv    <= w_drv_nxt;
      r_result <= w_result_nxt;
      r_flag_n <= w_flag_n_nxt;
      r_flag_z <= w_flag_z_nxt;
      r_flag_c <= w_flag_c_nxt;
      r_flag_v <= w_flag_v_nxt;
`ifdef ALU_SEQ_DECIMAL_EN
      r_d      <= w_d_nxt;
`endif
    end
  end

  assign bus.o_busy     = (r_state != StIdle);
  assign bus.o_done     = (r_state == StDone);
  assign bus.o_result   = r_result;
  assign bus.o_n        = r_flag_n;
  assign bus.o_z        = r_flag_z;
  assign bus.o_c        = r_flag_c;
  assign bus.o_v        = r_flag_v;
  assign bus.o_sb       = r_drv.sb;
  assign bus.o_db       = r_drv.db;
  assign bus.o_adl      = r_drv.adl;
  assign bus.o_sb_add   = r_drv.sb_add;
  assign bus.o_db_add   = r_drv.db_add;
  assign bus.o_db_n_add = r_drv.db_n_add;
  assign bus.o_adl_add  = r_drv.adl_add;
  assign bus.o_0_add    = r_drv.zero_add;
  assign bus.o_1_addc   = r_drv.one_addc;
  assign bus.o_sums     = r_drv.sums;
  assign bus.o_ands     = r_drv.ands;
  assign bus.o_eors     = r_drv.eors;
  assign bus.o_ors      = r_drv.ors;
  assign bus.o_srs      = r_drv.srs;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU, vector table and result scoreboard.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

`ifdef ALU_SEQ_DECIMAL_EN
  localparam bit DecEn = 1'b1;
`else
  localparam bit DecEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_sequencer_if bus ();

  alu_sequencer u_dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  typedef struct {
    logic [3:0]  op;
    logic [7:0]  a;
    logic [7:0]  m;
    logic        c;
    logic        v;
    logic        d;
    logic [7:0]  res;
    logic [3:0]  nzcv;
    int          lat;
    logic [10:0] sel;  // {sb,db,db_n,adl,0,1c,sums,ands,eors,ors,srs}
    logic [7:0]  sb;
    logic [7:0]  db;
    logic [1:0]  chk;  // [1] compare sb, [0] compare db
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
    int   id;
  } exp_t;

  vec_t tbl[14];
  exp_t exp_q[$];
  exp_t e_push, e_pop;
  vec_t cur;
  int   cur_id = 0;
  int   cyc = 0, m_cnt = 0, n_done = 0;
  int   n_chk = 0, n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [7:0] a, input logic [7:0] m,
                              input logic c, input logic v, input logic d,
                              input logic [7:0] res, input logic [3:0] nzcv, input int lat,
                              input logic [10:0] sel, input logic [7:0] sb,
                              input logic [7:0] db, input logic [1:0] chk);
    vec_t t;
    t.op = op; t.a = a; t.m = m; t.c = c; t.v = v; t.d = d;
    t.res = res; t.nzcv = nzcv; t.lat = lat; t.sel = sel; t.sb = sb; t.db = db; t.chk = chk;
    return t;
  endfunction

  function automatic logic [10:0] sel_now();
    return {bus.o_sb_add, bus.o_db_add, bus.o_db_n_add, bus.o_adl_add, bus.o_0_add,
            bus.o_1_addc, bus.o_sums, bus.o_ands, bus.o_eors, bus.o_ors, bus.o_srs};
  endfunction

  // Behavioural ALU: latches ADD on the falling edge from the driven lines.
  always @(negedge clk) begin
    logic [7:0] aa, bb;
    aa = bus.o_sb_add ? bus.o_sb : 8'h00;
    if (bus.o_db_add)        bb = bus.o_db;
    else if (bus.o_db_n_add) bb = ~bus.o_db;
    else if (bus.o_adl_add)  bb = bus.o_adl;
    else                     bb = 8'hFF;
    if (bus.o_sums)      bus.i_add = aa + bb + {7'd0, bus.o_1_addc};
    else if (bus.o_ands) bus.i_add = aa & bb;
    else if (bus.o_eors) bus.i_add = aa ^ bb;
    else if (bus.o_ors)  bus.i_add = aa | bb;
    else if (bus.o_srs)  bus.i_add = aa >> 1;
    else                 bus.i_add = 8'h00;
  end

  // Acceptance model: pushes an expectation each time an idle DUT sees i_req.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0;
      exp_q.delete();
    end else begin
      cyc++;
      if (m_cnt != 0) begin
        m_cnt--;
      end else if (bus.i_req) begin
        e_push.v   = cur;
        e_push.acc = cyc;
        e_push.id  = cur_id;
        exp_q.push_back(e_push);
        m_cnt = cur.lat + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", {63'd0, bus.o_busy}, {63'd0, m_cnt != 0});
      if (bus.o_done) begin
        n_done++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL done_unexpected: got o_done=1, expected no pending request");
        end else begin
          e_pop = exp_q.pop_front();
          check($sformatf("v%0d_result_nzcv", e_pop.id),
                {bus.o_result, bus.o_n, bus.o_z, bus.o_c, bus.o_v},
                {e_pop.v.res, e_pop.v.nzcv});
          check($sformatf("v%0d_latency", e_pop.id), cyc - e_pop.acc, e_pop.v.lat);
        end
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (m_cnt != 0 || exp_q.size() != 0) begin
      @(negedge clk);
      k++;
      if (k > 20) begin
        n_chk++;
        n_err++;
        $display("FAIL idle_timeout: got busy after %0d cycles, expected idle", k);
        exp_q.delete();
        break;
      end
    end
  endtask

  // Returns at the falling edge inside EXEC after checking the driven lines.
  task automatic start(input vec_t v, input int id);
    wait_idle();
    @(negedge clk);
    cur = v; cur_id = id;
    bus.i_op = v.op; bus.i_a = v.a; bus.i_m = v.m;
    bus.i_c = v.c; bus.i_v = v.v; bus.i_d = v.d;
    bus.i_req = 1'b1;
    @(negedge clk);
    bus.i_req = 1'b0;
    check($sformatf("v%0d_exec_sel", id), sel_now(), v.sel);
    check($sformatf("v%0d_exec_done", id), bus.o_done, 1'b0);
    if (v.chk[1]) check($sformatf("v%0d_exec_sb", id), bus.o_sb, v.sb);
    if (v.chk[0]) check($sformatf("v%0d_exec_db", id), bus.o_db, v.db);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected completion within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_done;
    bus.i_req = 1'b0; bus.i_op = '0; bus.i_a = '0; bus.i_m = '0;
    bus.i_c = 1'b0; bus.i_v = 1'b0; bus.i_d = 1'b0; bus.i_add = '0;
    cur = mk(4'd0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 4'h0, 1, 11'd0, 8'h00, 8'h00, 2'b00);

    tbl[0]  = mk(OpAdc, 8'h50, 8'h50, 0, 0, 0, 8'hA0, 4'b1001, 1, 11'b11000010000,
                 8'h50, 8'h50, 2'b11);
    tbl[1]  = mk(OpSbc, 8'h00, 8'h01, 1, 0, 0, 8'hFF, 4'b1000, 1, 11'b10100110000,
                 8'h00, 8'h01, 2'b11);
    tbl[2]  = mk(OpDec, 8'h33, 8'h00, 1, 1, 0, 8'hFF, 4'b1011, 1, 11'b10000010000,
                 8'h00, 8'h00, 2'b10);
    tbl[3]  = mk(OpInc, 8'h00, 8'hFF, 0, 1, 0, 8'h00, 4'b0101, 1, 11'b11000110000,
                 8'hFF, 8'h00, 2'b11);
    tbl[4]  = mk(OpCmp, 8'h40, 8'h40, 0, 1, 0, 8'h00, 4'b0111, 1, 11'b10100110000,
                 8'h40, 8'h40, 2'b11);
    tbl[5]  = mk(OpLsr, 8'h03, 8'h77, 0, 0, 0, 8'h01, 4'b0010, 1, 11'b10000000001,
                 8'h03, 8'h00, 2'b10);
    tbl[6]  = mk(4'hF,  8'h12, 8'h34, 1, 0, 0, 8'h00, 4'b0110, 1, 11'b00000000000,
                 8'h00, 8'h00, 2'b00);
    tbl[7]  = mk(OpAnd, 8'hF0, 8'h3C, 0, 1, 0, 8'h30, 4'b0001, 1, 11'b11000001000,
                 8'hF0, 8'h3C, 2'b11);
    tbl[8]  = mk(OpOra, 8'h81, 8'h02, 1, 0, 0, 8'h83, 4'b1010, 1, 11'b11000000010,
                 8'h81, 8'h02, 2'b11);
    tbl[9]  = mk(OpEor, 8'hAA, 8'hAA, 0, 0, 0, 8'h00, 4'b0100, 1, 11'b11000000100,
                 8'hAA, 8'hAA, 2'b11);
    tbl[10] = mk(OpAdc, 8'hFF, 8'h01, 1, 0, 0, 8'h01, 4'b0010, 1, 11'b11000110000,
                 8'hFF, 8'h01, 2'b11);
    tbl[11] = mk(OpSbc, 8'h50, 8'hB0, 1, 0, 0, 8'hA0, 4'b1001, 1, 11'b10100110000,
                 8'h50, 8'hB0, 2'b11);
    tbl[12] = mk(OpAdc, 8'h19, 8'h28, 0, 0, 1, DecEn ? 8'h47 : 8'h41, 4'b0000,
                 DecEn ? 2 : 1, 11'b11000010000, 8'h19, 8'h28, 2'b11);
    tbl[13] = mk(OpSbc, 8'h42, 8'h13, 1, 0, 1, DecEn ? 8'h29 : 8'h2F, 4'b0010,
                 DecEn ? 2 : 1, 11'b10100110000, 8'h42, 8'h13, 2'b11);

    repeat (2) @(negedge clk);
    check("reset_outputs",
          {bus.o_busy, bus.o_done, bus.o_result, bus.o_n, bus.o_z, bus.o_c, bus.o_v,
           bus.o_sb, bus.o_db, bus.o_adl, sel_now()}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      start(tbl[i], i);
      wait_idle();
    end

    // Decimal ADC and SBC, with the adjust pass inspected when it exists.
    start(tbl[12], 12);
`ifdef ALU_SEQ_DECIMAL_EN
    @(negedge clk);
    check("v12_adj_sel", sel_now(), 11'b10010010000);
    check("v12_adj_adl", bus.o_adl, 8'h06);
    check("v12_adj_sb", bus.o_sb, 8'h41);
`endif
    wait_idle();
    start(tbl[13], 13);
`ifdef ALU_SEQ_DECIMAL_EN
    @(negedge clk);
    check("v13_adj_sel", sel_now(), 11'b10100110000);
    check("v13_adj_db", bus.o_db, 8'h06);
    check("v13_adj_sb", bus.o_sb, 8'h2F);
`endif
    wait_idle();

    // Reset in EXEC clears everything at once; the next request still completes.
    start(tbl[0], 100);
    #2 rst_n = 1'b0;
    #1;
    check("reset_in_exec",
          {bus.o_busy, bus.o_done, bus.o_result, bus.o_n, bus.o_z, bus.o_c, bus.o_v,
           bus.o_sb, bus.o_db, bus.o_adl, sel_now()}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    base_done = n_done;
    start(tbl[1], 101);
    wait_idle();
    check("after_reset_done_count", n_done - base_done, 1);

    // Request held high for nine edges: accepted at edges 1, 4 and 7 only.
    wait_idle();
    @(negedge clk);
    base_done = n_done;
    cur = tbl[3]; cur_id = 102;
    bus.i_op = tbl[3].op; bus.i_a = tbl[3].a; bus.i_m = tbl[3].m;
    bus.i_c = tbl[3].c; bus.i_v = tbl[3].v; bus.i_d = tbl[3].d;
    bus.i_req = 1'b1;
    repeat (9) @(negedge clk);
    bus.i_req = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    check("held_req_dones", n_done - base_done, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Initiator-side driver for the 6502 ALU datapath. It accepts one arithmetic or logic request from the instruction control logic and drives the ALU operand-select and operation lines for one pass, or two passes in decimal mode. It reads back the ALU's ADD register and returns a registered result together with N/Z/C/V flags. It sits between the decode/timing logic and the ALU in the cpu6502 core.

## Interface
- No parameters.
- i_clk  in  1  system clock (phi2); ALU latches ADD on the falling edge
- i_reset_n  in  1  reset: asynchronous, active-low
- i_req  in  1  request strobe, sampled on rising edge in IDLE only
- i_op  in  4  operation code (package enum)
- i_a, i_m  in  8  accumulator operand, memory operand
- i_c, i_v, i_d  in  1  incoming carry, overflow, decimal flags
- o_busy  out  1  high in EXEC/ADJ/DONE
- o_done  out  1  one-cycle pulse; result and flags valid
- o_result  out  8  registered result
- o_n, o_z, o_c, o_v  out  1  registered flags
- o_sb, o_db, o_adl  out  8  ALU operand buses
- o_sb_add, o_db_add, o_db_n_add, o_adl_add, o_0_add, o_1_addc  out  1  ALU input selects and carry-in
- o_sums, o_ands, o_eors, o_ors, o_srs  out  1  ALU operation selects
- i_add  in  8  ALU ADD register

## Operation
- **States:** IDLE -> EXEC -> [ADJ] -> DONE -> IDLE.
  - In IDLE, i_req=1 latches the operands and op, then moves to EXEC.
  - i_req while busy is ignored. There is no queuing.
- **EXEC drive.** All ALU lines are registered, so they are stable across the mid-cycle falling edge.
  - ADC: sb=a, sb_add, db=m, db_add, 1_addc=c, sums.
  - SBC: as ADC but with db_n_add instead of db_add.
  - AND / ORA / EOR: sb=a, db=m, sb_add, db_add, plus ands / ors / eors.
  - LSR: sb=a, sb_add, srs.
  - INC: sb=m, sb_add, db=0x00, db_add, 1_addc=1, sums.
  - DEC: sb=m, sb_add, no B select (ALU default B=0xFF), 1_addc=0, sums.
  - CMP: sb=a, db=m, sb_add, db_n_add, 1_addc=1, sums.
  - Illegal op: all selects low, so the ALU yields 0x00.
- **Capture.** i_add is captured at the rising edge ending EXEC (or ADJ). All ALU lines return to 0 in DONE and IDLE.
- **Flags.** Computed internally from the registered operands and a 9-bit sum of effective A + B + cin.
  - N = r[7]; Z = (r == 0).
  - C: carry-out for ADC/SBC/CMP; a[0] for LSR; otherwise i_c.
  - V: for ADC/SBC, V = ((a^r) & (B^r))[7] with B the effective (possibly inverted) operand; otherwise i_v.
- **Reset (async, any state):** state IDLE, and every output 0 (o_busy, o_done, o_result, flags, buses, selects).

## Timing
- Request accepted at edge k.
  - EXEC occupies cycle k..k+1.
  - Binary ops: DONE (o_done=1) occupies k+1..k+2.
  - Decimal ops: ADJ occupies k+1..k+2 and DONE occupies k+2..k+3.
- o_result and flags change only on entry to DONE and hold until the next DONE.
- Throughput: one binary op every 3 cycles. IDLE is required between ops.

## Configuration
- **ALU_SEQ_DECIMAL_EN defined:** ADC/SBC with i_d=1 insert ADJ. The adjust constant uses 0x06 and/or 0x60 per nibble/carry rules.
  - ADC: sb=binary result, adl=adjust, adl_add, sums, 1_addc=0.
  - SBC: sb=result, db=adjust, db_n_add, 1_addc=1.
  - C = decimal carry. N/Z come from the adjusted result. V comes from the binary pass.
- **Undefined:** i_d is ignored, ADJ does not exist, and the ALU adl lines are tied 0.

## Structure
- Package alu_seq_pkg holds:
  - op enum: ADC=0, SBC=1, AND=2, ORA=3, EOR=4, LSR=5, INC=6, DEC=7, CMP=8;
  - state encoding;
  - BCD constants 0x06 / 0x60.
- One sub-module, alu_seq_bcd_adjust: combinational adjust-constant and decimal-carry generation, instantiated only under the macro.

## Test plan
- ADC a=0x50 m=0x50 c=0 -> in EXEC db_add=1, sums=1; o_done at k+1; result 0xA0, N=1 Z=0 C=0 V=1.
- SBC a=0x00 m=0x01 c=1 -> in EXEC db_n_add=1, o_db=0x01; result 0xFF, N=1 C=0 V=0.
- DEC m=0x00 -> no B select asserted, result 0xFF, C/V equal inputs. INC m=0xFF -> 0x00, Z=1.
- CMP a=0x40 m=0x40 -> Z=1 C=1, V=i_v. LSR a=0x03 -> 0x01, C=1. Illegal op 0xF -> 0x00, Z=1.
- Decimal ADC a=0x19 m=0x28 d=1:
  - with macro: ADJ asserts adl_add with o_adl=0x06; result 0x47, o_done at k+2;
  - without macro: 0x41 at k+1.
- Mixed boundaries:
  - reset asserted in EXEC -> all outputs 0 immediately, then the next request completes normally;
  - i_req held through busy -> exactly one o_done per IDLE acceptance.
